fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 81 ++++++++
 tb/tb_fwd_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight producers past ID, generates load-use stalls and per-port forward selects.
// Define FWD_PERF_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module fwd_scoreboard #(
  parameter int STAGES = 3,
  parameter int NREAD  = 2,
  parameter int AW     = 5,
  parameter int LW     = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     id_valid,
  input  logic [NREAD*AW-1:0]                      id_rs_addr,
  input  logic [NREAD-1:0]                         id_rs_use,
  input  logic                                     id_wr_en,
  input  logic [AW-1:0]                            id_wr_addr,
  input  logic [LW-1:0]                            id_wr_lat,
  input  logic                                     flush,
  output logic                                     stall,
  output logic [NREAD*$clog2(STAGES+1)-1:0]        ex_fwd_sel,
  output logic [31:0]                              stall_cnt
);

  localparam int SW = $clog2(STAGES + 1);

  logic          entValid [STAGES];
  logic [AW-1:0] entAddr  [STAGES];
  logic [LW-1:0] entLat   [STAGES];

  logic [SW-1:0]    selNext [NREAD];
  logic [NREAD-1:0] portHazard;
  logic             issue;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      selNext[p]    = '0;
      portHazard[p] = 1'b0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (id_rs_use[p] && entValid[i] && (entAddr[i] != '0) &&
            (entAddr[i] == id_rs_addr[p*AW +: AW])) begin
          selNext[p]    = SW'(i + 1);
          portHazard[p] = int'(entLat[i]) > i;
        end
      end
    end
  end

  assign stall = ~reset & id_valid & ~flush & (|portHazard);
  assign issue = id_valid & ~stall & ~flush;

  // Entries advance every cycle; a stalled or flushed slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) entValid[i] <= 1'b0;
      ex_fwd_sel <= '0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        entValid[i] <= entValid[i-1];
        entAddr[i]  <= entAddr[i-1];
        entLat[i]   <= entLat[i-1];
      end
      entValid[0] <= issue & id_wr_en;
      entAddr[0]  <= id_wr_addr;
      entLat[0]   <= id_wr_lat;
      for (int p = 0; p < NREAD; p++)
        ex_fwd_sel[p*SW +: SW] <= issue ? selNext[p] : '0;
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: default instance plus a STAGES=4/NREAD=3 instance.
module tb_fwd_scoreboard;

`ifdef FWD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        idValid, idWrEn, flush, stall;
  logic [9:0]  idRsAddr;
  logic [1:0]  idRsUse, idWrLat;
  logic [4:0]  idWrAddr;
  logic [3:0]  exFwdSel;
  logic [31:0] stallCnt;

  logic        v4, wrEn4, flush4, stall4;
  logic [14:0] rsAddr4;
  logic [2:0]  rsUse4;
  logic [1:0]  wrLat4;
  logic [4:0]  wrAddr4;
  logic [8:0]  exFwdSel4;
  logic [31:0] stallCnt4;

  int checks = 0;
  int passes = 0;
  int expCnt = 0;
  logic [8:0] expQ[$];
  logic [8:0] expSel;

  fwd_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs_addr(idRsAddr),
    .id_rs_use(idRsUse), .id_wr_en(idWrEn), .id_wr_addr(idWrAddr),
    .id_wr_lat(idWrLat), .flush(flush), .stall(stall),
    .ex_fwd_sel(exFwdSel), .stall_cnt(stallCnt)
  );

  fwd_scoreboard #(.STAGES(4), .NREAD(3)) dut4 (
    .clk(clk), .reset(reset), .id_valid(v4), .id_rs_addr(rsAddr4),
    .id_rs_use(rsUse4), .id_wr_en(wrEn4), .id_wr_addr(wrAddr4),
    .id_wr_lat(wrLat4), .flush(flush4), .stall(stall4),
    .ex_fwd_sel(exFwdSel4), .stall_cnt(stallCnt4)
  );

  task automatic setIn(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] u, input logic we, input logic [4:0] wa,
                       input logic [1:0] wl, input logic fl);
    idValid = v; idRsAddr = {a1, a0}; idRsUse = u;
    idWrEn = we; idWrAddr = wa; idWrLat = wl; flush = fl;
    #1;
  endtask

  task automatic setIn4(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [2:0] u, input logic we,
                        input logic [4:0] wa, input logic [1:0] wl, input logic fl);
    v4 = v; rsAddr4 = {a2, a1, a0}; rsUse4 = u;
    wrEn4 = we; wrAddr4 = wa; wrLat4 = wl; flush4 = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    setIn(0, 0, 0, 2'b00, 0, 0, 0, 0);
    setIn4(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    repeat (5) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    setIn(0, 0, 0, 2'b00, 0, 0, 0, 0);
    setIn4(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    tick(); tick();
    checks++; if (stall !== 1'b0) $display("[TB] FAIL rst_stall got=%0b want=0", stall); else passes++;
    checks++; if (exFwdSel !== 4'h0) $display("[TB] FAIL rst_sel got=%0h want=0", exFwdSel); else passes++;
    checks++; if (stallCnt !== 32'h0) $display("[TB] FAIL rst_cnt got=%0h want=0", stallCnt); else passes++;
    checks++; if (stall4 !== 1'b0) $display("[TB] FAIL rst_stall4 got=%0b want=0", stall4); else passes++;
    checks++; if (exFwdSel4 !== 9'h0) $display("[TB] FAIL rst_sel4 got=%0h want=0", exFwdSel4); else passes++;
    checks++; if (stallCnt4 !== 32'h0) $display("[TB] FAIL rst_cnt4 got=%0h want=0", stallCnt4); else passes++;
    reset = 1'b0;
    expCnt = 0;
  endtask

  task automatic test_alu_chain;
    idle();
    setIn(1, 1, 2, 2'b11, 1, 3, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL alu_a_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL alu_a_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    setIn(1, 3, 7, 2'b11, 1, 8, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL alu_b_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h001); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL alu_b_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    setIn(1, 3, 8, 2'b11, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL alu_c_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h006); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL alu_c_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    setIn(1, 8, 3, 2'b10, 0, 0, 0, 0);
    expQ.push_back(9'h00C); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL alu_use_mask_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
  endtask

  task automatic test_load_use;
    idle();
    setIn(1, 0, 0, 2'b00, 1, 4, 1, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL lu_load_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL lu_load_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    setIn(1, 4, 0, 2'b01, 1, 6, 0, 0);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL lu_stall1 got=%0b want=1", stall); else passes++;
    expCnt++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL lu_bubble_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL lu_stall2 got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h002); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL lu_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    checks++; if (stallCnt !== (PERF ? 32'(expCnt) : 32'h0)) $display("[TB] FAIL lu_cnt got=%0d want=%0d", stallCnt, PERF ? expCnt : 0); else passes++;
  endtask

  task automatic test_priority;
    idle();
    setIn(1, 0, 0, 2'b00, 1, 5, 0, 0); tick();
    setIn(1, 0, 0, 2'b00, 1, 5, 0, 0); tick();
    setIn(1, 5, 5, 2'b11, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL prio_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h005); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL prio_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    // Youngest producer is a load: it governs the stall even though an older ALU result exists.
    idle();
    setIn(1, 0, 0, 2'b00, 1, 5, 0, 0); tick();
    setIn(1, 0, 0, 2'b00, 1, 5, 1, 0); tick();
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 0);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL prio_load_stall got=%0b want=1", stall); else passes++;
    expCnt++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL prio_load_bubble got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL prio_load_stall2 got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h002); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL prio_load_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
  endtask

  task automatic test_zero_reg;
    idle();
    setIn(1, 0, 0, 2'b00, 1, 0, 1, 0); tick();
    setIn(1, 0, 0, 2'b11, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL zero_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL zero_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
  endtask

  task automatic test_flush;
    idle();
    setIn(1, 0, 0, 2'b00, 1, 4, 1, 0); tick();
    setIn(1, 4, 0, 2'b01, 1, 9, 0, 1);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL flush_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL flush_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
    // The flushed instruction's $9 must not appear; the load is now one slot older.
    setIn(1, 9, 4, 2'b11, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL flush_after_stall got=%0b want=0", stall); else passes++;
    expQ.push_back(9'h008); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel !== expSel[3:0]) $display("[TB] FAIL flush_bubble_sel got=%0h want=%0h", exFwdSel, expSel[3:0]); else passes++;
  endtask

  task automatic test_stages4_depth;
    idle();
    setIn4(1, 0, 0, 0, 3'b000, 1, 7, 0, 0); tick();
    setIn4(0, 0, 0, 0, 3'b000, 0, 0, 0, 0); repeat (3) tick();
    setIn4(1, 0, 0, 7, 3'b100, 0, 0, 0, 0);
    checks++; if (stall4 !== 1'b0) $display("[TB] FAIL s4_far4_stall got=%0b want=0", stall4); else passes++;
    expQ.push_back(9'h100); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel4 !== expSel) $display("[TB] FAIL s4_far4_sel got=%0h want=%0h", exFwdSel4, expSel); else passes++;
    setIn4(1, 0, 0, 0, 3'b000, 1, 11, 0, 0); tick();
    setIn4(0, 0, 0, 0, 3'b000, 0, 0, 0, 0); repeat (4) tick();
    setIn4(1, 0, 0, 11, 3'b100, 0, 0, 0, 0);
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel4 !== expSel) $display("[TB] FAIL s4_far5_sel got=%0h want=%0h", exFwdSel4, expSel); else passes++;
  endtask

  task automatic test_stages4_lat3;
    idle();
    setIn4(1, 0, 0, 0, 3'b000, 1, 12, 3, 0); tick();
    setIn4(1, 12, 0, 0, 3'b001, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (stall4 !== 1'b1) $display("[TB] FAIL s4_lat3_stall%0d got=%0b want=1", k, stall4); else passes++;
      tick();
    end
    checks++; if (stall4 !== 1'b0) $display("[TB] FAIL s4_lat3_release got=%0b want=0", stall4); else passes++;
    expQ.push_back(9'h004); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel4 !== expSel) $display("[TB] FAIL s4_lat3_sel got=%0h want=%0h", exFwdSel4, expSel); else passes++;
  endtask

  task automatic test_reset_mid_stall;
    idle();
    setIn4(1, 0, 0, 0, 3'b000, 1, 12, 3, 0); tick();
    setIn4(1, 12, 0, 0, 3'b001, 0, 0, 0, 0);
    checks++; if (stall4 !== 1'b1) $display("[TB] FAIL rms_pre_stall got=%0b want=1", stall4); else passes++;
    tick();
    reset = 1'b1; #1;
    checks++; if (stall4 !== 1'b0) $display("[TB] FAIL rms_stall_in_reset got=%0b want=0", stall4); else passes++;
    tick();
    checks++; if (exFwdSel4 !== 9'h0) $display("[TB] FAIL rms_sel got=%0h want=0", exFwdSel4); else passes++;
    checks++; if (stallCnt4 !== 32'h0) $display("[TB] FAIL rms_cnt4 got=%0h want=0", stallCnt4); else passes++;
    checks++; if (stallCnt !== 32'h0) $display("[TB] FAIL rms_cnt got=%0h want=0", stallCnt); else passes++;
    reset = 1'b0; expCnt = 0; #1;
    checks++; if (stall4 !== 1'b0) $display("[TB] FAIL rms_post_stall got=%0b want=0", stall4); else passes++;
    expQ.push_back(9'h000); tick(); expSel = expQ.pop_front();
    checks++; if (exFwdSel4 !== expSel) $display("[TB] FAIL rms_post_sel got=%0h want=%0h", exFwdSel4, expSel); else passes++;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_flush();
    test_stages4_depth();
    test_stages4_lat3();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
